// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter stage feeding the single-cycle control decoder.
// Holds the PC and selects the next PC from the decoder's PCSrc. It also
// synchronises irq_in and latches each rising edge as a pending IRQ.
// Optional feature: define PC_EPC_EN to add the EPC output and its register.
// SYNC_STAGES must be at least 2.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VEC   = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VEC   = 32'h8000_0004,
    parameter logic [31:0] XADR_VEC    = 32'h8000_0008,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  PCSrc,
    input  logic        ALUOut0,
    input  logic [31:0] Imm32,
    input  logic [25:0] JT,
    input  logic [31:0] DataBusA,
    input  logic        imem_ready,
    input  logic        irq_in,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic        PC_sv,
    output logic        IRQ
`ifdef PC_EPC_EN
    ,
    output logic [31:0] EPC
`endif
);

    logic [31:0]            pc_q;
    logic [31:0]            pc_d;
    logic [31:0]            pc_plus4;
    logic [31:0]            con_ba;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   pend_q;
    logic                   pend_d;
    logic                   irq_rise;

    assign pc_plus4 = pc_q + 32'd4;
    assign con_ba   = pc_plus4 + (Imm32 << 2);

    // Next-PC select; the low two bits are always cleared so the PC stays word aligned.
    always_comb begin
        pc_d = pc_plus4;
        unique case (PCSrc)
            3'b000:  pc_d = pc_plus4;
            3'b001:  pc_d = ALUOut0 ? con_ba : pc_plus4;
            3'b010:  pc_d = {pc_plus4[31:28], JT, 2'b00};
            3'b011:  pc_d = DataBusA;
            3'b100:  pc_d = ILLOP_VEC;
            default: pc_d = XADR_VEC;   // 101 exception, 110/111 illegal codes
        endcase
        pc_d[1:0] = 2'b00;
    end

    // PC register: advances only when instruction memory has the current word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_VEC;
        end else if (imem_ready) begin
            pc_q <= pc_d;
        end
    end

    // A rising edge at the synchroniser output sets pending; a new edge beats a simultaneous clear.
    assign irq_rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

    // Pending-interrupt next state: set on edge, cleared when the interrupt vector is taken.
    always_comb begin
        pend_d = pend_q;
        if (irq_rise) begin
            pend_d = 1'b1;
        end else if (imem_ready && (PCSrc == 3'b100)) begin
            pend_d = 1'b0;
        end
    end

    // Synchroniser and pending flag; the chain keeps shifting during a stall so edges are not lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], irq_in};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            pend_q      <= pend_d;
        end
    end

`ifdef PC_EPC_EN
    logic [31:0] epc_q;

    // Exception PC: an interrupt re-executes the interrupted instruction, an exception skips it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            epc_q <= '0;
        end else if (imem_ready) begin
            if (PCSrc == 3'b100) begin
                epc_q <= pc_q;
            end else if (PCSrc[2]) begin
                epc_q <= pc_plus4;
            end
        end
    end

    assign EPC = epc_q;
`endif

    assign PC       = pc_q;
    assign PC_plus4 = pc_plus4;
    assign PC_sv    = pc_q[31];
    assign IRQ      = pend_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vectors followed by randomized traffic.
// A reference model predicts the state after each clock edge.
// A monitor pops each prediction and compares it against the DUT outputs.
module tb_pc_fetch_unit;

    localparam int          S  = 2;
    localparam logic [31:0] RV = 32'h8000_0000;
    localparam logic [31:0] IV = 32'h8000_0004;
    localparam logic [31:0] XV = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  PCSrc;
    logic        ALUOut0;
    logic [31:0] Imm32;
    logic [25:0] JT;
    logic [31:0] DataBusA;
    logic        imem_ready;
    logic        irq_in;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        PC_sv;
    logic        IRQ;
`ifdef PC_EPC_EN
    logic [31:0] EPC;
`endif

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_VEC  (RV),
        .ILLOP_VEC  (IV),
        .XADR_VEC   (XV),
        .SYNC_STAGES(S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .PCSrc     (PCSrc),
        .ALUOut0   (ALUOut0),
        .Imm32     (Imm32),
        .JT        (JT),
        .DataBusA  (DataBusA),
        .imem_ready(imem_ready),
        .irq_in    (irq_in),
        .PC        (PC),
        .PC_plus4  (PC_plus4),
        .PC_sv     (PC_sv),
        .IRQ       (IRQ)
`ifdef PC_EPC_EN
        ,
        .EPC       (EPC)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        irq;
        logic [31:0] epc;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_pend;
    bit          irq_log[$];   // irq_in value seen at each non-reset edge since the last reset

    function automatic bit sample(input int k);
        return (k >= 0 && k < irq_log.size()) ? irq_log[k] : 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge state, and queue it.
    task automatic step(input logic rst, input logic [2:0] src, input logic alu,
                        input logic [31:0] imm, input logic [25:0] jt, input logic [31:0] dba,
                        input logic rdy, input logic irq);
        logic [31:0] p4;
        logic [31:0] npc;
        bit          rose;
        int          n;
        exp_t        e;
        reset      = rst;
        PCSrc      = src;
        ALUOut0    = alu;
        Imm32      = imm;
        JT         = jt;
        DataBusA   = dba;
        imem_ready = rdy;
        irq_in     = irq;
        if (!rst) begin
            m_pc   = RV;
            m_pend = 1'b0;
            m_epc  = 32'd0;
            irq_log.delete();
        end else begin
            // An edge that reached irq_in S+1 samples ago is visible now.
            n    = irq_log.size();
            rose = sample(n - S) && !sample(n - S - 1);
            p4   = m_pc + 32'd4;
            if (rdy) begin
                case (src)
                    3'd0:    npc = p4;
                    3'd1:    npc = alu ? p4 + imm * 32'd4 : p4;
                    3'd2:    npc = (p4 & 32'hF000_0000) | ({6'd0, jt} * 32'd4);
                    3'd3:    npc = dba;
                    3'd4:    npc = IV;
                    default: npc = XV;
                endcase
                if (src == 3'd4) begin
                    m_epc  = m_pc;
                    m_pend = 1'b0;
                end else if (src >= 3'd5) begin
                    m_epc = p4;
                end
                m_pc = npc & ~32'd3;
            end
            if (rose) m_pend = 1'b1;
            irq_log.push_back(irq);
        end
        e.pc  = m_pc;
        e.irq = m_pend;
        e.epc = m_epc;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one prediction per clock edge, checked 1 ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("PC", PC, e.pc);
                chk("PC_plus4", PC_plus4, e.pc + 32'd4);
                chk("PC_sv", {31'd0, PC_sv}, {31'd0, e.pc[31]});
                chk("IRQ", {31'd0, IRQ}, {31'd0, e.irq});
`ifdef PC_EPC_EN
                chk("EPC", EPC, e.epc);
`endif
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic [31:0] imm;
        logic        lvl;
        reset = 1'b0; PCSrc = 3'd0; ALUOut0 = 1'b0; Imm32 = '0; JT = '0;
        DataBusA = '0; imem_ready = 1'b1; irq_in = 1'b0;

        // Reset, then sequential fetch from the reset vector.
        step(0, 3'd0, 0, 32'd0, 26'd0, 32'd0, 1, 0);
        step(0, 3'd0, 0, 32'd0, 26'd0, 32'd0, 1, 0);
        repeat (3) step(1, 3'd0, 0, 32'd0, 26'd0, 32'd0, 1, 0);

        // Branch taken backwards, and not taken.
        step(1, 3'd3, 0, 32'd0, 26'd0, 32'h0000_0100, 1, 0);
        step(1, 3'd1, 1, 32'hFFFF_FFFE, 26'd0, 32'd0, 1, 0);
        step(1, 3'd3, 0, 32'd0, 26'd0, 32'h0000_0100, 1, 0);
        step(1, 3'd1, 0, 32'hFFFF_FFFE, 26'd0, 32'd0, 1, 0);

        // Jump, then jr to a misaligned user address.
        step(1, 3'd3, 0, 32'd0, 26'd0, 32'h0040_0010, 1, 0);
        step(1, 3'd2, 0, 32'd0, 26'h000_0040, 32'd0, 1, 0);
        step(1, 3'd3, 0, 32'd0, 26'd0, 32'h0040_0003, 1, 0);

        // One-cycle irq pulse, IRQ after three clocks, then take the interrupt.
        step(1, 3'd0, 0, 32'd0, 26'd0, 32'd0, 1, 1);
        repeat (3) step(1, 3'd0, 0, 32'd0, 26'd0, 32'd0, 1, 0);
        step(1, 3'd4, 0, 32'd0, 26'd0, 32'd0, 1, 0);
        step(1, 3'd0, 0, 32'd0, 26'd0, 32'd0, 1, 0);

        // Stall with a pending jump and an irq edge, then release.
        step(1, 3'd3, 0, 32'd0, 26'd0, 32'h0040_0000, 1, 0);
        repeat (4) step(1, 3'd2, 0, 32'd0, 26'h012_3456, 32'd0, 0, 1);
        step(1, 3'd2, 0, 32'd0, 26'h012_3456, 32'd0, 1, 1);
        // Level held high: no second event after the clear.
        repeat (3) step(1, 3'd0, 0, 32'd0, 26'd0, 32'd0, 1, 1);
        step(1, 3'd4, 0, 32'd0, 26'd0, 32'd0, 1, 1);
        repeat (5) step(1, 3'd0, 0, 32'd0, 26'd0, 32'd0, 1, 1);

        // New edge lands on the same edge as a clear: pending stays set.
        step(1, 3'd0, 0, 32'd0, 26'd0, 32'd0, 1, 0);
        step(1, 3'd0, 0, 32'd0, 26'd0, 32'd0, 1, 1);
        step(1, 3'd0, 0, 32'd0, 26'd0, 32'd0, 1, 0);
        step(1, 3'd4, 0, 32'd0, 26'd0, 32'd0, 1, 0);
        step(1, 3'd4, 0, 32'd0, 26'd0, 32'd0, 1, 0);

        // Exception entry, stall, reset in the middle of the stall.
        step(1, 3'd3, 0, 32'd0, 26'd0, 32'h0040_0020, 1, 0);
        step(1, 3'd5, 0, 32'd0, 26'd0, 32'd0, 1, 0);
        step(1, 3'd6, 0, 32'd0, 26'd0, 32'd0, 0, 0);
        step(1, 3'd7, 0, 32'd0, 26'd0, 32'd0, 0, 0);
        step(0, 3'd2, 0, 32'd0, 26'h3FF_FFFF, 32'd0, 0, 0);
        step(1, 3'd0, 0, 32'd0, 26'd0, 32'd0, 1, 0);

        // Randomized traffic.
        lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom;
            imm = ($urandom_range(0, 1) != 0) ? $urandom : {{26{r[5]}}, r[5:0]};
            if ($urandom_range(0, 7) == 0) lvl = ~lvl;
            step(($urandom_range(0, 199) != 0),
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 imm,
                 26'($urandom),
                 $urandom,
                 ($urandom_range(0, 3) != 0),
                 lvl);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
